tconv2d_4x4_stride2_layer: RTL and testbench

TCONV2D_4X4_STRIDE2_LAYER -- requirements
Module: tconv2d_4x4_stride2_layer

---
 rtl/tconv2d_4x4_stride2_layer_pkg.sv | 14 +
 rtl/qmult.sv | 17 +
 rtl/tconv2d_4x4_stride2_layer_mac4.sv | 29 ++
 rtl/tconv2d_4x4_stride2_layer.sv | 204 ++++++++++++++++++++
 tb/tb_tconv2d_4x4_stride2_layer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tconv2d_4x4_stride2_layer_pkg.sv
// Shared definitions for the 4x4 stride-2 transposed-convolution layer:
// default word width, Q-format fraction bits and FSM state encoding.
package tconv2d_4x4_stride2_layer_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAC_BITS      = 8;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/qmult.sv
// Signed fixed-point multiply: full-precision product, arithmetic shift by
// FRAC_BITS, result truncated (wrapped) back to DATA_WIDTH.
module qmult #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] y
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = a * b;
  assign y    = prod[FRAC_BITS+DATA_WIDTH-1:FRAC_BITS];

endmodule

// File: rtl/tconv2d_4x4_stride2_layer_mac4.sv
// Combinational 4-tap multiply-accumulate: four qmult products plus bias,
// summed with DATA_WIDTH wrap-around.
module tconv_mac4
  import tconv2d_4x4_stride2_layer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic signed [DATA_WIDTH-1:0] x    [4],
  input  logic signed [DATA_WIDTH-1:0] w    [4],
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic signed [DATA_WIDTH-1:0] sum
);

  logic signed [DATA_WIDTH-1:0] prod [4];

  for (genvar i = 0; i < 4; i++) begin : g_mult
    qmult #(
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_BITS (FRAC_BITS)
    ) u_qmult (
      .a(w[i]),
      .b(x[i]),
      .y(prod[i])
    );
  end

  assign sum = bias + prod[0] + prod[1] + prod[2] + prod[3];

endmodule

// File: rtl/tconv2d_4x4_stride2_layer.sv
// Streaming 4x4 transposed convolution, stride 2, pad 1, with two row buffers.
// Optional ReLU on the output is enabled by defining TCONV_RELU_EN.
module tconv2d_4x4_stride2_layer
  import tconv2d_4x4_stride2_layer_pkg::*;
#(
  parameter int IMG_WIDTH  = 16,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] w0,
  input  logic signed [DATA_WIDTH-1:0] w1,
  input  logic signed [DATA_WIDTH-1:0] w2,
  input  logic signed [DATA_WIDTH-1:0] w3,
  input  logic signed [DATA_WIDTH-1:0] w4,
  input  logic signed [DATA_WIDTH-1:0] w5,
  input  logic signed [DATA_WIDTH-1:0] w6,
  input  logic signed [DATA_WIDTH-1:0] w7,
  input  logic signed [DATA_WIDTH-1:0] w8,
  input  logic signed [DATA_WIDTH-1:0] w9,
  input  logic signed [DATA_WIDTH-1:0] w10,
  input  logic signed [DATA_WIDTH-1:0] w11,
  input  logic signed [DATA_WIDTH-1:0] w12,
  input  logic signed [DATA_WIDTH-1:0] w13,
  input  logic signed [DATA_WIDTH-1:0] w14,
  input  logic signed [DATA_WIDTH-1:0] w15,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] data_out
);

  localparam int CW = $clog2(2 * IMG_WIDTH);
  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  state_t          state;
  logic [CW-1:0]   col;        // input column in FILL, output column otherwise
  logic [XW-1:0]   row;        // input row just completed
  logic            odd_row;    // 1: emitting output row 2r-1, 0: row 2r
  logic            first_row;
  logic            cur_sel;    // physical buffer currently acting as "cur"

  logic signed [DATA_WIDTH-1:0] buf0 [IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0] buf1 [IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0] w    [16];

  assign w[0]  = w0;
  assign w[1]  = w1;
  assign w[2]  = w2;
  assign w[3]  = w3;
  assign w[4]  = w4;
  assign w[5]  = w5;
  assign w[6]  = w6;
  assign w[7]  = w7;
  assign w[8]  = w8;
  assign w[9]  = w9;
  assign w[10] = w10;
  assign w[11] = w11;
  assign w[12] = w12;
  assign w[13] = w13;
  assign w[14] = w14;
  assign w[15] = w15;

  // Tap selection. Even output index 2n draws from inputs n-1 (kernel 3) and
  // n (kernel 1); odd index 2n+1 draws from n (kernel 2) and n+1 (kernel 0).
  // The top row is always prev, the bottom row is cur (zero while flushing).
  logic            odd_col;
  logic [XW-1:0]   n;
  logic            left_ok, right_ok, top_ok, bot_ok;
  logic [XW-1:0]   left_idx, right_idx;
  logic [1:0]      ky_t, ky_b, kx_l, kx_r;
  logic signed [DATA_WIDTH-1:0] prev_l, prev_r, cur_l, cur_r;
  logic signed [DATA_WIDTH-1:0] tap_x [4];
  logic signed [DATA_WIDTH-1:0] tap_w [4];
  logic signed [DATA_WIDTH-1:0] sum;
  logic signed [DATA_WIDTH-1:0] result;

  // NOTE: every always_comb output gets a value on every path, so no latches.
  always_comb begin
    odd_col   = col[0];
    n         = XW'(col >> 1);
    left_ok   = odd_col || (n != '0);
    right_ok  = !odd_col || (n != XW'(IMG_WIDTH - 1));
    left_idx  = '0;
    right_idx = '0;
    if (left_ok)  left_idx  = odd_col ? n : n - 1'b1;
    if (right_ok) right_idx = odd_col ? n + 1'b1 : n;
    top_ok    = !first_row;
    bot_ok    = (state != ST_FLUSH);

    ky_t = odd_row ? 2'd2 : 2'd3;
    ky_b = odd_row ? 2'd0 : 2'd1;
    kx_l = odd_col ? 2'd2 : 2'd3;
    kx_r = odd_col ? 2'd0 : 2'd1;

    prev_l = cur_sel ? buf0[left_idx]  : buf1[left_idx];
    prev_r = cur_sel ? buf0[right_idx] : buf1[right_idx];
    cur_l  = cur_sel ? buf1[left_idx]  : buf0[left_idx];
    cur_r  = cur_sel ? buf1[right_idx] : buf0[right_idx];

    tap_x[0] = (top_ok && left_ok)  ? prev_l : '0;
    tap_x[1] = (top_ok && right_ok) ? prev_r : '0;
    tap_x[2] = (bot_ok && left_ok)  ? cur_l  : '0;
    tap_x[3] = (bot_ok && right_ok) ? cur_r  : '0;

    tap_w[0] = w[{ky_t, kx_l}];
    tap_w[1] = w[{ky_t, kx_r}];
    tap_w[2] = w[{ky_b, kx_l}];
    tap_w[3] = w[{ky_b, kx_r}];
  end

  tconv_mac4 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mac4 (
    .x   (tap_x),
    .w   (tap_w),
    .bias(bias),
    .sum (sum)
  );

`ifdef TCONV_RELU_EN
  assign result = sum[DATA_WIDTH-1] ? '0 : sum;
`else
  assign result = sum;
`endif

  // NOTE: row buffers carry no reset; first_row and the tap masks keep stale
  // contents from ever reaching the output.
  always_ff @(posedge clk) begin
    if (state == ST_FILL && valid_in && in_ready) begin
      if (cur_sel) buf1[XW'(col)] <= data_in;
      else         buf0[XW'(col)] <= data_in;
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      in_ready  <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
      col       <= '0;
      row       <= '0;
      odd_row   <= 1'b0;
      first_row <= 1'b1;
      cur_sel   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        ST_FILL: begin
          in_ready <= 1'b1;
          if (valid_in && in_ready) begin
            if (col == CW'(IMG_WIDTH - 1)) begin
              col      <= '0;
              in_ready <= 1'b0;
              odd_row  <= !first_row;  // input row 0 yields only output row 0
              state    <= ST_EMIT;
            end else begin
              col <= col + 1'b1;
            end
          end
        end

        ST_EMIT, ST_FLUSH: begin
          valid_out <= 1'b1;
          data_out  <= result;
          if (col == CW'(2 * IMG_WIDTH - 1)) begin
            col <= '0;
            if (state == ST_EMIT && odd_row) begin
              odd_row <= 1'b0;
            end else if (state == ST_EMIT) begin
              cur_sel   <= ~cur_sel;
              first_row <= 1'b0;
              if (row == XW'(IMG_WIDTH - 1)) begin
                row     <= '0;
                odd_row <= 1'b1;
                state   <= ST_FLUSH;
              end else begin
                row      <= row + 1'b1;
                in_ready <= 1'b1;
                state    <= ST_FILL;
              end
            end else begin
              first_row <= 1'b1;
              in_ready  <= 1'b1;
              state     <= ST_FILL;
            end
          end else begin
            col <= col + 1'b1;
          end
        end

        default: begin
          in_ready <= 1'b0;
          state    <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tconv2d_4x4_stride2_layer.sv
// Randomised self-checking bench for tconv2d_4x4_stride2_layer (IMG_WIDTH=2,
// Q8.8) against a direct transposed-convolution reference model.
module tb_tconv2d_4x4_stride2_layer;

  localparam int N    = 2;
  localparam int DW   = 16;
  localparam int NOUT = 4 * N * N;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 valid_in = 1'b0;
  logic signed [DW-1:0] data_in = '0;
  logic                 in_ready;
  logic                 valid_out;
  logic signed [DW-1:0] data_out;
  logic signed [DW-1:0] wt [16];
  logic signed [DW-1:0] bias_v;
  logic signed [DW-1:0] pix [N*N];
  logic        [DW-1:0] exp_o [NOUT];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] got_q [$];
  int acc_cnt = 0;

  always #5 clk = ~clk;

  tconv2d_4x4_stride2_layer #(
    .IMG_WIDTH (N),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .data_in  (data_in),
    .in_ready (in_ready),
    .w0 (wt[0]),  .w1 (wt[1]),  .w2 (wt[2]),  .w3 (wt[3]),
    .w4 (wt[4]),  .w5 (wt[5]),  .w6 (wt[6]),  .w7 (wt[7]),
    .w8 (wt[8]),  .w9 (wt[9]),  .w10(wt[10]), .w11(wt[11]),
    .w12(wt[12]), .w13(wt[13]), .w14(wt[14]), .w15(wt[15]),
    .bias     (bias_v),
    .valid_out(valid_out),
    .data_out (data_out)
  );

  always @(negedge clk) if (valid_out) got_q.push_back(data_out);
  always @(posedge clk) if (rst_n && valid_in && in_ready) acc_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] qm(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    p = p >>> 8;
    return p[DW-1:0];
  endfunction

  // out[oy][ox] = bias + sum w[ky*4+kx]*in[iy][ix], oy=2iy+ky-1, ox=2ix+kx-1
  task automatic compute_exp();
    logic [DW-1:0] acc;
    int ky, kx;
    for (int oy = 0; oy < 2 * N; oy++) begin
      for (int ox = 0; ox < 2 * N; ox++) begin
        acc = bias_v;
        for (int iy = 0; iy < N; iy++) begin
          for (int ix = 0; ix < N; ix++) begin
            ky = oy + 1 - 2 * iy;
            kx = ox + 1 - 2 * ix;
            if (ky >= 0 && ky < 4 && kx >= 0 && kx < 4)
              acc = acc + qm(wt[ky*4+kx], pix[iy*N+ix]);
          end
        end
`ifdef TCONV_RELU_EN
        if (acc[DW-1]) acc = '0;
`endif
        exp_o[oy*2*N+ox] = acc;
      end
    end
  endtask

  function automatic logic signed [DW-1:0] rnd();
    return DW'($urandom_range(0, 2047)) - 16'sd1024;
  endfunction

  task automatic send_pixels(input int gap_pct, input bit hold);
    int t;
    for (int p = 0; p < N * N; p++) begin
      if (!hold) begin
        while ($urandom_range(0, 99) < gap_pct) begin
          valid_in = 1'b0;
          @(posedge clk); #1;
        end
      end
      valid_in = 1'b1;
      data_in  = pix[p];
      t = 0;
      while (!in_ready && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 200) check("accept_tmo", DW'(t), '0);
      @(posedge clk); #1;
    end
    if (!hold) valid_in = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int gap_pct, input bit hold, output int base);
    int abase, t;
    base  = got_q.size();
    abase = acc_cnt;
    compute_exp();
    send_pixels(gap_pct, hold);
    t = 0;
    while (got_q.size() - base < NOUT && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    valid_in = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check({tag, "_count"}, DW'(got_q.size() - base), DW'(NOUT));
    check({tag, "_accepts"}, DW'(acc_cnt - abase), DW'(N * N));
    for (int i = 0; i < NOUT; i++)
      if (base + i < got_q.size())
        check($sformatf("%s_px%0d", tag, i), got_q[base+i], exp_o[i]);
  endtask

  task automatic set_ones();
    for (int k = 0; k < 16; k++) wt[k] = 16'sh0100;
    for (int p = 0; p < N * N; p++) pix[p] = 16'sh0100;
    bias_v = '0;
  endtask

  task automatic check_ones(input string tag, input int base);
    int fy, fx;
    for (int oy = 0; oy < 4; oy++) begin
      for (int ox = 0; ox < 4; ox++) begin
        fy = (oy == 0 || oy == 3) ? 1 : 2;
        fx = (ox == 0 || ox == 3) ? 1 : 2;
        if (base + oy * 4 + ox < got_q.size())
          check($sformatf("%s_gold%0d%0d", tag, oy, ox), got_q[base+oy*4+ox], DW'(fy * fx * 256));
      end
    end
  endtask

  initial begin
    int base, pre;
    logic [DW-1:0] neg_exp;

    for (int k = 0; k < 16; k++) wt[k] = '0;
    for (int p = 0; p < N * N; p++) pix[p] = '0;
    bias_v = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", DW'(in_ready), '0);
    check("rst_valid_out", DW'(valid_out), '0);
    check("rst_data_out", data_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", DW'(in_ready), 16'd1);

    // All-ones golden, gap-free
    set_ones();
    run_frame("ones", 0, 1'b0, base);
    check_ones("ones", base);

    // Impulse with w_k = k
    for (int k = 0; k < 16; k++) wt[k] = DW'(k * 256);
    for (int p = 0; p < N * N; p++) pix[p] = '0;
    pix[0] = 16'sh0100;
    run_frame("imp", 0, 1'b0, base);
    check("imp_00", got_q[base+0],  16'h0500);
    check("imp_01", got_q[base+1],  16'h0600);
    check("imp_10", got_q[base+4],  16'h0900);
    check("imp_22", got_q[base+10], 16'h0F00);
    check("imp_33", got_q[base+15], 16'h0000);

    // valid_in held high for the whole frame
    set_ones();
    run_frame("hold", 0, 1'b1, base);
    check_ones("hold", base);

    // Random gaps in FILL
    run_frame("gaps", 50, 1'b0, base);
    check_ones("gaps", base);

    // Zero input, negative bias
    for (int p = 0; p < N * N; p++) pix[p] = '0;
    bias_v = 16'shFF00;
`ifdef TCONV_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hFF00;
`endif
    run_frame("negb", 0, 1'b0, base);
    for (int i = 0; i < NOUT; i++)
      check($sformatf("negb_gold%0d", i), got_q[base+i], neg_exp);

    // Random frames with random gaps
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++) wt[k] = rnd();
      for (int p = 0; p < N * N; p++) pix[p] = rnd();
      bias_v = rnd();
      run_frame($sformatf("rand%0d", f), 30, 1'b0, base);
    end

    // Reset pulsed while emitting after the second input row
    for (int p = 0; p < N * N; p++) pix[p] = rnd();
    send_pixels(0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("abort_valid_low", DW'(valid_out), '0);
    pre = got_q.size();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("abort_quiet", DW'(got_q.size() - pre), '0);
    check("abort_in_ready", DW'(in_ready), 16'd1);
    for (int k = 0; k < 16; k++) wt[k] = rnd();
    for (int p = 0; p < N * N; p++) pix[p] = rnd();
    bias_v = rnd();
    run_frame("fresh", 20, 1'b0, base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
